// File: rtl/moore_cmd_sequencer.sv
// moore_cmd_sequencer: turns (op, count) requests into the 2-bit mode/execute
// code stream for a Moore output-cell receiver, while shadowing the receiver
// mode and predicting its output bit.
module moore_cmd_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] req_count,
  output logic [1:0]       ain,
  output logic [1:0]       mode,
  output logic             aout_pred,
  output logic             pred_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EXEC   = 2'd2
  } state_e;

  localparam logic [1:0]       CODE_EXEC   = 2'b00;
  localparam logic [1:0]       CODE_CLEAR  = 2'b01;
  localparam logic [1:0]       CODE_TOGGLE = 2'b10;
  localparam logic [1:0]       CODE_SET    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       ain_q, ain_d;
  logic [1:0]       mode_q, mode_d;
  logic             aoutPred_q, aoutPred_d;
  logic             predValid_q, predValid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state logic: request decode, select/execute sequencing and output prediction.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ain_d       = ain_q;
    mode_d      = mode_q;
    aoutPred_d  = aoutPred_q;
    predValid_d = predValid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op == CODE_EXEC) begin
            err_d = 1'b1;
          end else if (req_op != mode_q) begin
            ain_d       = req_op;
            mode_d      = req_op;
            remaining_d = req_count;
            state_d     = SELECT;
          end else if (req_count != CNT_ZERO) begin
            ain_d       = CODE_EXEC;
            remaining_d = req_count - CNT_ONE;
            state_d     = EXEC;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SELECT: begin
        if (remaining_q != CNT_ZERO) begin
          ain_d       = CODE_EXEC;
          remaining_d = remaining_q - CNT_ONE;
          state_d     = EXEC;
        end else begin
          ain_d   = mode_q;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      EXEC: begin
        if (remaining_q != CNT_ZERO) begin
          remaining_d = remaining_q - CNT_ONE;
        end else begin
          ain_d   = mode_q;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        ain_d   = mode_q;
        state_d = IDLE;
      end
    endcase

    if (ain_q == CODE_EXEC) begin
      case (mode_q)
        CODE_CLEAR: begin
          aoutPred_d  = 1'b0;
          predValid_d = 1'b1;
        end
        CODE_SET: begin
          aoutPred_d  = 1'b1;
          predValid_d = 1'b1;
        end
        CODE_TOGGLE: aoutPred_d = ~aoutPred_q;
        default: ;
      endcase
    end
  end

  // State register; reset mirrors the receiver's own reset so the shadow stays coherent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ain_q       <= CODE_CLEAR;
      mode_q      <= CODE_CLEAR;
      aoutPred_q  <= 1'b0;
      predValid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ain_q       <= ain_d;
      mode_q      <= mode_d;
      aoutPred_q  <= aoutPred_d;
      predValid_q <= predValid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ain        = ain_q;
  assign mode       = mode_q;
  assign aout_pred  = aoutPred_q;
  assign pred_valid = predValid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_moore_cmd_sequencer.sv
// Directed self-checking bench for moore_cmd_sequencer: every step compares the
// full output vector {ain, mode, aout_pred, pred_valid, req_ready, busy, done, err}
// against hand-computed values.
module tb_moore_cmd_sequencer;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_count;
  logic [1:0] ain;
  logic [1:0] mode;
  logic       aout_pred;
  logic       pred_valid;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int execCount;
  int cycleCount;

  moore_cmd_sequencer #(.CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_count (req_count),
    .ain       (ain),
    .mode      (mode),
    .aout_pred (aout_pred),
    .pred_valid(pred_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] cnt);
    req_valid = v;
    req_op    = op;
    req_count = cnt;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs: ain, mode, aout_pred, pred_valid, req_ready, busy, done, err.
  task automatic expectState(input string tag, input logic [1:0] eAin, input logic [1:0] eMode,
                             input logic eAp, input logic ePv, input logic eRdy,
                             input logic eBusy, input logic eDone, input logic eErr);
    checkOutput(tag, {ain, mode, aout_pred, pred_valid, req_ready, busy, done, err},
                {eAin, eMode, eAp, ePv, eRdy, eBusy, eDone, eErr});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 4'd0);
    #1;
    expectState("reset_state", 2'b01, 2'b01, 0, 0, 1, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    expectState("idle_after_reset", 2'b01, 2'b01, 0, 0, 1, 0, 0, 0);

    // Set x3 from mode 01: select cycle then three executes.
    applyStimulus(1'b1, 2'b11, 4'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("set3_select", 2'b11, 2'b11, 0, 0, 0, 1, 0, 0);
    tick();
    expectState("set3_exec1", 2'b00, 2'b11, 0, 0, 0, 1, 0, 0);
    tick();
    expectState("set3_exec2", 2'b00, 2'b11, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("set3_exec3", 2'b00, 2'b11, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("set3_done", 2'b11, 2'b11, 1, 1, 1, 0, 1, 0);

    // Set x2 while already in set mode: no select cycle.
    applyStimulus(1'b1, 2'b11, 4'd2);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("same_exec1", 2'b00, 2'b11, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("same_exec2", 2'b00, 2'b11, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("same_done", 2'b11, 2'b11, 1, 1, 1, 0, 1, 0);
    tick();
    expectState("same_idle", 2'b11, 2'b11, 1, 1, 1, 0, 0, 0);

    // Toggle before any clear/set leaves the prediction unknown.
    reset = 1'b1;
    #1;
    expectState("reset_again", 2'b01, 2'b01, 0, 0, 1, 0, 0, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 2'b10, 4'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("tog3_select", 2'b10, 2'b10, 0, 0, 0, 1, 0, 0);
    tick();
    expectState("tog3_exec1", 2'b00, 2'b10, 0, 0, 0, 1, 0, 0);
    tick();
    expectState("tog3_exec2", 2'b00, 2'b10, 1, 0, 0, 1, 0, 0);
    tick();
    expectState("tog3_exec3", 2'b00, 2'b10, 0, 0, 0, 1, 0, 0);
    tick();
    expectState("tog3_done", 2'b10, 2'b10, 1, 0, 1, 0, 1, 0);

    // Clear x1 makes the prediction valid.
    applyStimulus(1'b1, 2'b01, 4'd1);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("clr1_select", 2'b01, 2'b01, 1, 0, 0, 1, 0, 0);
    tick();
    expectState("clr1_exec", 2'b00, 2'b01, 1, 0, 0, 1, 0, 0);
    tick();
    expectState("clr1_done", 2'b01, 2'b01, 0, 1, 1, 0, 1, 0);

    // Toggle x3 from known 0 ends at 1.
    applyStimulus(1'b1, 2'b10, 4'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("tog3b_select", 2'b10, 2'b10, 0, 1, 0, 1, 0, 0);
    tick();
    expectState("tog3b_exec1", 2'b00, 2'b10, 0, 1, 0, 1, 0, 0);
    tick();
    tick();
    tick();
    expectState("tog3b_done", 2'b10, 2'b10, 1, 1, 1, 0, 1, 0);

    // Illegal op: single err pulse, nothing else moves.
    applyStimulus(1'b1, 2'b00, 4'd5);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("illegal_err", 2'b10, 2'b10, 1, 1, 1, 0, 0, 1);
    tick();
    expectState("illegal_after", 2'b10, 2'b10, 1, 1, 1, 0, 0, 0);

    // Clear x0 from toggle mode: select only, no execute.
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("clr0_select", 2'b01, 2'b01, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("clr0_done", 2'b01, 2'b01, 1, 1, 1, 0, 1, 0);

    // Clear x0 from clear mode: done next cycle, stays idle.
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("same0_done", 2'b01, 2'b01, 1, 1, 1, 0, 1, 0);
    tick();
    expectState("same0_idle", 2'b01, 2'b01, 1, 1, 1, 0, 0, 0);

    // New request held during EXEC is ignored until the done cycle, then taken.
    applyStimulus(1'b1, 2'b01, 4'd2);
    tick();
    applyStimulus(1'b1, 2'b11, 4'd1);
    expectState("b2b_exec1", 2'b00, 2'b01, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("b2b_exec2", 2'b00, 2'b01, 0, 1, 0, 1, 0, 0);
    tick();
    expectState("b2b_done", 2'b01, 2'b01, 0, 1, 1, 0, 1, 0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("b2b_select", 2'b11, 2'b11, 0, 1, 0, 1, 0, 0);
    tick();
    expectState("b2b_exec", 2'b00, 2'b11, 0, 1, 0, 1, 0, 0);
    tick();
    expectState("b2b_done2", 2'b11, 2'b11, 1, 1, 1, 0, 1, 0);

    // Reset in the 2nd execute cycle of toggle x5 drops the request.
    applyStimulus(1'b1, 2'b10, 4'd5);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    expectState("rst_select", 2'b10, 2'b10, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("rst_exec1", 2'b00, 2'b10, 1, 1, 0, 1, 0, 0);
    tick();
    expectState("rst_exec2", 2'b00, 2'b10, 0, 1, 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    expectState("rst_async", 2'b01, 2'b01, 0, 0, 1, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    expectState("rst_no_done", 2'b01, 2'b01, 0, 0, 1, 0, 0, 0);

    // Maximum count: all-ones issues exactly 15 executes.
    applyStimulus(1'b1, 2'b01, 4'd15);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    execCount  = 0;
    cycleCount = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ain == 2'b00) execCount++;
      cycleCount++;
      tick();
    end
    checkOutput("max_exec_count", execCount[9:0], 10'd15);
    checkOutput("max_latency", cycleCount[9:0], 10'd15);
    expectState("max_done", 2'b01, 2'b01, 0, 1, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
